// File: rtl/branch_hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller.
// Latency defaults, scoreboard entry layout and flush FSM states.
package branch_hazard_unit_pkg;

  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rw;
    logic              ld;
  } sb_entry_t;

  typedef enum logic {
    FL_IDLE,
    FL_FLUSH
  } flush_state_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: registered {v, rw, ld} plus its conflict check.
// K is the slot index; slot 0 holds the instruction currently in EX.
module hazard_scoreboard_entry #(
  parameter int AW       = 5,
  parameter int K        = 0,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_v,
  input  logic [AW-1:0] d_rw,
  input  logic          d_ld,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic          branch,
  output logic          q_v,
  output logic [AW-1:0] q_rw,
  output logic          q_ld,
  output logic          conflict
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rw;
    logic          ld;
  } entry_t;

  // Branches consume in ID (need 0), others in EX (need 1).
  localparam bit ALU_BR = (K < ALU_LAT);
  localparam bit ALU_NB = (K + 1 < ALU_LAT);
  localparam bit LD_BR  = (K < LOAD_LAT);
  localparam bit LD_NB  = (K + 1 < LOAD_LAT);

  entry_t e_q;
  logic   hit_a;
  logic   hit_b;
  logic   in_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else begin
      e_q.v  <= d_v;
      e_q.rw <= d_rw;
      e_q.ld <= d_ld;
    end
  end

  assign q_v  = e_q.v;
  assign q_rw = e_q.rw;
  assign q_ld = e_q.ld;

  assign hit_a = (src_a != '0) && (e_q.rw == src_a);
  assign hit_b = (src_b != '0) && (e_q.rw == src_b);

  assign in_win = e_q.ld ? (branch ? LD_BR : LD_NB)
                         : (branch ? ALU_BR : ALU_NB);

  assign conflict = e_q.v && (hit_a || hit_b) && in_win;

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage hazard controller: operand-readiness stall, taken-branch
// IF/ID flush sequencing and a saturating stall counter.
module branch_hazard_unit #(
  parameter int REG_AW       = branch_hazard_unit_pkg::REG_AW,
  parameter int DEPTH        = branch_hazard_unit_pkg::DEPTH,
  parameter int ALU_LAT      = branch_hazard_unit_pkg::ALU_LAT,
  parameter int LOAD_LAT     = branch_hazard_unit_pkg::LOAD_LAT,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_Ra,
  input  logic [REG_AW-1:0] id_Rb,
  input  logic              id_Branch,
  input  logic              id_RegWr,
  input  logic              id_MemtoReg,
  input  logic [REG_AW-1:0] id_Rw,
  input  logic              id_branch_taken,
  output logic              id_stall,
  output logic              if_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  import branch_hazard_unit_pkg::*;

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);

  logic [DEPTH-1:0]  d_v;
  logic [DEPTH-1:0]  d_ld;
  logic [REG_AW-1:0] d_rw [DEPTH];
  logic [DEPTH-1:0]  e_v;
  logic [DEPTH-1:0]  e_ld;
  logic [REG_AW-1:0] e_rw [DEPTH];
  logic [DEPTH-1:0]  conf;

  flush_state_e   state_q;
  flush_state_e   state_d;
  logic [FCW-1:0] fcnt_q;
  logic [FCW-1:0] fcnt_d;

  logic flush_active;
  logic valid_eff;
  logic take;
  logic unused_tail;

  // A nonzero counter means ID holds a wrong-path instruction.
  assign flush_active = (fcnt_q != '0);
  assign valid_eff    = id_valid && !flush_active;

  assign id_stall = !rst && valid_eff && (|conf);
  assign take     = !rst && id_branch_taken && valid_eff && !id_stall;
  assign if_flush = !rst && (take || flush_active);

  for (genvar k = 0; k < DEPTH; k++) begin : g_sb
    if (k == 0) begin : g_head
      assign d_v[k]  = valid_eff && !id_stall && id_RegWr &&
                       (id_Rw != '0);
      assign d_rw[k] = id_Rw;
      assign d_ld[k] = id_MemtoReg;
    end else begin : g_body
      assign d_v[k]  = e_v[k-1];
      assign d_rw[k] = e_rw[k-1];
      assign d_ld[k] = e_ld[k-1];
    end

    hazard_scoreboard_entry #(
      .AW       (REG_AW),
      .K        (k),
      .ALU_LAT  (ALU_LAT),
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .d_v      (d_v[k]),
      .d_rw     (d_rw[k]),
      .d_ld     (d_ld[k]),
      .src_a    (id_Ra),
      .src_b    (id_Rb),
      .branch   (id_Branch),
      .q_v      (e_v[k]),
      .q_rw     (e_rw[k]),
      .q_ld     (e_ld[k]),
      .conflict (conf[k])
    );
  end

  // The oldest slot only feeds its own compare.
  assign unused_tail = ^{e_v[DEPTH-1], e_ld[DEPTH-1], e_rw[DEPTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FL_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      FL_IDLE: begin
        if (take) begin
          fcnt_d = FC_LOAD;
          if (FC_LOAD != '0) state_d = FL_FLUSH;
        end
      end
      FL_FLUSH: begin
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q == FCW'(1)) state_d = FL_IDLE;
      end
      default: begin
        state_d = FL_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: two configurations driven in lockstep,
// checked each cycle against an age-list model plus pinned literals.
module tb_branch_hazard_unit;

  import branch_hazard_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_Ra;
  logic [4:0] id_Rb;
  logic       id_Branch;
  logic       id_RegWr;
  logic       id_MemtoReg;
  logic [4:0] id_Rw;
  logic       id_branch_taken;

  logic        stall_a, flush_a;
  logic [15:0] cnt_a;
  logic        stall_b, flush_b;
  logic [1:0]  cnt_b;

  int n_pass  = 0;
  int n_total = 0;
  bit run_chk = 0;

  always #5 clk = ~clk;

  branch_hazard_unit #(
    .REG_AW(5), .DEPTH(3), .ALU_LAT(1), .LOAD_LAT(2),
    .FLUSH_CYCLES(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .id_Branch(id_Branch),
    .id_RegWr(id_RegWr), .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw),
    .id_branch_taken(id_branch_taken),
    .id_stall(stall_a), .if_flush(flush_a), .stall_cnt(cnt_a)
  );

  branch_hazard_unit #(
    .REG_AW(5), .DEPTH(4), .ALU_LAT(1), .LOAD_LAT(3),
    .FLUSH_CYCLES(2), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_Ra(id_Ra), .id_Rb(id_Rb), .id_Branch(id_Branch),
    .id_RegWr(id_RegWr), .id_MemtoReg(id_MemtoReg), .id_Rw(id_Rw),
    .id_branch_taken(id_branch_taken),
    .id_stall(stall_b), .if_flush(flush_b), .stall_cnt(cnt_b)
  );

  // Model: each in-flight producer carries its age (0 = in EX).
  typedef struct {
    int        age;
    sb_entry_t e;
  } prod_t;
  typedef prod_t pq_t[$];

  pq_t q0, q1;
  int  fr0 = 0, fr1 = 0;
  int  cnt0 = 0, cnt1 = 0;

  function automatic bit m_stall(pq_t q, int ll, int fr);
    int need;
    bit hit;
    hit  = 0;
    need = id_Branch ? 0 : 1;
    if (rst || !id_valid || fr != 0) return 0;
    foreach (q[i]) begin
      if ((q[i].e.rw == id_Ra || q[i].e.rw == id_Rb) &&
          (q[i].age + need < (q[i].e.ld ? ll : 1)))
        hit = 1;
    end
    return hit;
  endfunction

  function automatic bit m_take(pq_t q, int ll, int fr);
    return !rst && id_branch_taken && id_valid && fr == 0 &&
           !m_stall(q, ll, fr);
  endfunction

  function automatic bit m_flush(pq_t q, int ll, int fr);
    return !rst && (m_take(q, ll, fr) || fr != 0);
  endfunction

  task automatic m_step(inout pq_t q, inout int fr, inout int cnt,
                        input int dep, input int ll, input int fc,
                        input int cmax);
    pq_t   nq;
    prod_t p;
    bit    st, tk;
    st = m_stall(q, ll, fr);
    tk = m_take(q, ll, fr);
    if (rst) begin
      q.delete();
      fr  = 0;
      cnt = 0;
    end else begin
      foreach (q[i]) begin
        if (q[i].age + 1 < dep) begin
          p = q[i];
          p.age++;
          nq.push_back(p);
        end
      end
      if (id_valid && fr == 0 && !st && id_RegWr && id_Rw != 0) begin
        p.age  = 0;
        p.e.v  = 1'b1;
        p.e.rw = id_Rw;
        p.e.ld = id_MemtoReg;
        nq.push_back(p);
      end
      if (st && cnt < cmax) cnt++;
      if (fr > 0) fr--;
      else if (tk) fr = fc - 1;
      q = nq;
    end
  endtask

  always @(posedge clk) begin
    m_step(q0, fr0, cnt0, 3, 2, 1, 65535);
    m_step(q1, fr1, cnt1, 4, 3, 2, 3);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_stall_a", 32'(stall_a), 32'(m_stall(q0, 2, fr0)));
      chk("m_flush_a", 32'(flush_a), 32'(m_flush(q0, 2, fr0)));
      chk("m_cnt_a",   32'(cnt_a),   32'(cnt0));
      chk("m_stall_b", 32'(stall_b), 32'(m_stall(q1, 3, fr1)));
      chk("m_flush_b", 32'(flush_b), 32'(m_flush(q1, 3, fr1)));
      chk("m_cnt_b",   32'(cnt_b),   32'(cnt1));
    end
  end

  task automatic drv(input bit v, input bit br, input bit tk,
                     input bit we, input bit ld, input int rw,
                     input int ra, input int rb);
    id_valid        = v;
    id_Branch       = br;
    id_branch_taken = tk;
    id_RegWr        = we;
    id_MemtoReg     = ld;
    id_Rw           = 5'(rw);
    id_Ra           = 5'(ra);
    id_Rb           = 5'(rb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    drv(1, 1, 1, 1, 1, 4, 0, 0);
    tick();
    run_chk = 1;
    at_neg();
    chk("rst_stall_a", 32'(stall_a), 0);
    chk("rst_flush_a", 32'(flush_a), 0);
    chk("rst_flush_b", 32'(flush_b), 0);
    tick();
    rst = 1'b0;
    idle(1);
    at_neg();
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_stall_b", 32'(stall_b), 0);

    // load r5, then branch on r5
    drv(1, 0, 0, 1, 1, 5, 1, 2);
    tick();
    drv(1, 1, 0, 0, 0, 0, 5, 0);
    at_neg();
    chk("ldbr_a_c1", 32'(stall_a), 1);
    chk("ldbr_b_c1", 32'(stall_b), 1);
    tick();
    at_neg();
    chk("ldbr_a_c2", 32'(stall_a), 1);
    chk("ldbr_b_c2", 32'(stall_b), 1);
    tick();
    at_neg();
    chk("ldbr_a_c3", 32'(stall_a), 0);
    chk("ldbr_b_c3", 32'(stall_b), 1);
    tick();
    at_neg();
    chk("ldbr_b_c4", 32'(stall_b), 0);
    idle(1);
    at_neg();
    chk("ldbr_cnt_a", 32'(cnt_a), 2);
    chk("ldbr_cnt_b", 32'(cnt_b), 3);
    idle(4);

    // ALU r3, then branch on r3/r4
    drv(1, 0, 0, 1, 0, 3, 0, 0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 3, 4);
    at_neg();
    chk("alubr_a_c1", 32'(stall_a), 1);
    tick();
    at_neg();
    chk("alubr_a_c2", 32'(stall_a), 0);
    idle(3);

    // ALU r3, then non-branch consumer
    drv(1, 0, 0, 1, 0, 3, 0, 0);
    tick();
    drv(1, 0, 0, 1, 0, 8, 3, 0);
    at_neg();
    chk("aluadd_a", 32'(stall_a), 0);
    chk("aluadd_b", 32'(stall_b), 0);
    idle(3);

    // load r7, then add using r7
    drv(1, 0, 0, 1, 1, 7, 0, 0);
    tick();
    drv(1, 0, 0, 1, 0, 9, 7, 0);
    at_neg();
    chk("ldadd_a_c1", 32'(stall_a), 1);
    chk("ldadd_b_c1", 32'(stall_b), 1);
    tick();
    at_neg();
    chk("ldadd_a_c2", 32'(stall_a), 0);
    chk("ldadd_b_c2", 32'(stall_b), 1);
    tick();
    at_neg();
    chk("ldadd_b_c3", 32'(stall_b), 0);
    chk("cnt_b_sat", 32'(cnt_b), 3);
    idle(4);

    // producer writing r0 never stalls
    drv(1, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("r0_a", 32'(stall_a), 0);
    chk("r0_b", 32'(stall_b), 0);
    idle(3);

    // taken branch; B holds flush a second cycle
    drv(1, 1, 1, 0, 0, 0, 1, 2);
    at_neg();
    chk("tk_flush_a_t0", 32'(flush_a), 1);
    chk("tk_flush_b_t0", 32'(flush_b), 1);
    tick();
    drv(1, 0, 0, 1, 1, 9, 0, 0);
    at_neg();
    chk("tk_flush_a_t1", 32'(flush_a), 0);
    chk("tk_flush_b_t1", 32'(flush_b), 1);
    chk("tk_stall_b_t1", 32'(stall_b), 0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 9, 0);
    at_neg();
    chk("tk_entry_a", 32'(stall_a), 1);
    chk("tk_noentry_b", 32'(stall_b), 0);
    chk("tk_flush_b_t2", 32'(flush_b), 0);
    idle(4);

    // taken branch with a conflict: stall wins
    drv(1, 0, 0, 1, 0, 6, 0, 0);
    tick();
    drv(1, 1, 1, 0, 0, 0, 6, 0);
    at_neg();
    chk("tkc_stall_a", 32'(stall_a), 1);
    chk("tkc_flush_a", 32'(flush_a), 0);
    chk("tkc_flush_b", 32'(flush_b), 0);
    tick();
    at_neg();
    chk("tkc_flush_a2", 32'(flush_a), 1);
    chk("tkc_flush_b2", 32'(flush_b), 1);
    tick();
    drv(1, 1, 1, 0, 0, 0, 1, 2);
    at_neg();
    chk("tkc_flush_b3", 32'(flush_b), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("tkc_ignored_b", 32'(flush_b), 0);
    idle(3);

    // reset in the middle of a stall
    drv(1, 0, 0, 1, 1, 2, 0, 0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 2, 0);
    at_neg();
    chk("rs_stall_b", 32'(stall_b), 1);
    tick();
    rst = 1'b1;
    at_neg();
    chk("rs_during_a", 32'(stall_a), 0);
    chk("rs_during_b", 32'(stall_b), 0);
    tick();
    rst = 1'b0;
    at_neg();
    chk("rs_after_b", 32'(stall_b), 0);
    chk("rs_cnt_b", 32'(cnt_b), 0);
    idle(3);

    // reset in the middle of a flush
    drv(1, 1, 1, 0, 0, 0, 1, 2);
    tick();
    rst = 1'b1;
    at_neg();
    chk("rf_during_b", 32'(flush_b), 0);
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("rf_after_b", 32'(flush_b), 0);
    idle(3);

    // sustained stalls drive the 2-bit counter to saturation
    for (int r = 0; r < 2; r++) begin
      drv(1, 0, 0, 1, 1, 2, 0, 0);
      tick();
      drv(1, 1, 0, 0, 0, 0, 2, 0);
      for (int i = 0; i < 3; i++) tick();
      idle(4);
    end
    at_neg();
    chk("sat_cnt_b", 32'(cnt_b), 3);

    run_chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
